// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative radix-2 shift-add multiplier controller for the
// execute stage. Accepts MUL / UMULL / SMULL, holds the pipeline via stall
// while iterating, then issues a one-cycle write-back on two register ports.
//
// Optional feature macro: MUL_EARLY_TERM_EN
//   defined   -> ITER ends once the remaining multiplier is zero (min 1 iter)
//   undefined -> ITER always runs WIDTH iterations
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   start, op           request and operation (00 MUL, 01 UMULL, 10 SMULL, 11 MUL)
//   src_a, src_b        multiplicand (Rm), multiplier (Rs)
//   wa_lo, wa_hi        destination registers for low / high product word
//   flush               abort current or requested operation
//   stall               combinational pipeline hold request
//   done, we            registered write-back strobe and port enables
//   wa3, wa3_2          registered write addresses for port 1 / port 2
//   result_lo/hi        registered product words
module mul_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       wa_lo,
    input  logic [3:0]       wa_hi,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [1:0]       we,
    output logic [3:0]       wa3,
    output logic [3:0]       wa3_2,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_iter;
    logic               w_fix;
    logic               w_last;

    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [PW-1:0]      r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign;
    logic               r_long;
    logic [3:0]         r_wa_lo;
    logic [3:0]         r_wa_hi;

    logic               w_signed;
    logic               w_long;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_mplier_nxt;
    logic [PW-1:0]      w_acc_sum;
    logic [PW-1:0]      w_prod;
    logic [1:0]         w_we_val;

    // Operand decode: SMULL works on magnitudes and fixes the sign afterwards.
    assign w_signed = (op == 2'b10);
    assign w_long   = (op == 2'b01) || (op == 2'b10);
    assign w_abs_a  = (w_signed && src_a[WIDTH-1]) ? WIDTH'(~src_a + 1'b1) : src_a;
    assign w_abs_b  = (w_signed && src_b[WIDTH-1]) ? WIDTH'(~src_b + 1'b1) : src_b;

    // One shift-add step and the final sign correction.
    assign w_mplier_nxt = r_mplier >> 1;
    assign w_acc_sum    = r_mplier[0] ? PW'(r_acc + r_mcand) : r_acc;
    assign w_prod       = r_sign ? PW'(~r_acc + 1'b1) : r_acc;

    // Long op to a single register writes only the high word.
    assign w_we_val = !r_long ? 2'b01 : ((r_wa_lo == r_wa_hi) ? 2'b10 : 2'b11);

`ifdef MUL_EARLY_TERM_EN
    assign w_last = (w_mplier_nxt == '0) || (r_cnt == CNT_W'(WIDTH - 1));
`else
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

    // Stall is forced low while reset is asserted so a mid-operation reset
    // drops the hold immediately.
    assign stall = reset && (((r_state == S_IDLE) && start && !flush) ||
                             (r_state == S_ITER) || (r_state == S_FIX));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control; flush overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_iter      = 1'b0;
        w_fix       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ITER;
                    w_load      = 1'b1;
                end
            end
            S_ITER: begin
                w_iter = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_fix       = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_load      = 1'b0;
            w_iter      = 1'b0;
            w_fix       = 1'b0;
        end
    end

    // Datapath and registered write-back outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sign    <= 1'b0;
            r_long    <= 1'b0;
            r_wa_lo   <= '0;
            r_wa_hi   <= '0;
            done      <= 1'b0;
            we        <= 2'b00;
            wa3       <= '0;
            wa3_2     <= '0;
            result_lo <= '0;
            result_hi <= '0;
        end else begin
            if (w_load) begin
                r_mcand  <= PW'(w_abs_a);
                r_mplier <= w_abs_b;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_sign   <= w_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                r_long   <= w_long;
                r_wa_lo  <= wa_lo;
                r_wa_hi  <= wa_hi;
            end else if (w_iter) begin
                r_acc    <= w_acc_sum;
                r_mcand  <= PW'(r_mcand << 1);
                r_mplier <= w_mplier_nxt;
                r_cnt    <= CNT_W'(r_cnt + 1'b1);
            end else if (w_fix) begin
                r_acc    <= w_prod;
            end

            done <= w_fix;
            we   <= w_fix ? w_we_val : 2'b00;
            if (w_fix) begin
                wa3       <= r_wa_lo;
                wa3_2     <= r_wa_hi;
                result_lo <= w_prod[WIDTH-1:0];
                result_hi <= w_prod[PW-1:WIDTH];
            end
        end
    end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative multi-cycle multiplier controller for the pipelined core's execute stage. It accepts MUL, UMULL and SMULL operations from E, holds the pipeline through a stall request while a radix-2 shift-add engine iterates, then issues a single-cycle write-back request. The write-back drives the register file's two write ports: low word on the first port, high word on the second.

## Interface
- WIDTH, 32: operand width; the product is 2*WIDTH bits.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; the block resets while reset is 0.
- start  input  1  E-stage request; sampled only in IDLE.
- op  input  2  operation: 00 MUL, 01 UMULL, 10 SMULL, 11 treated as MUL.
- src_a  input  WIDTH  multiplicand (Rm).
- src_b  input  WIDTH  multiplier (Rs).
- wa_lo  input  4  destination for the low word.
- wa_hi  input  4  destination for the high word (long ops only).
- flush  input  1  abort the current or requested operation.
- stall  output  1  pipeline hold request to the hazard unit.
- done  output  1  one-cycle write-back strobe.
- we  output  2  bit0 writes port 1 (low word), bit1 writes port 2 (high word); valid only with done.
- wa3, wa3_2  output  4  write addresses for port 1 and port 2.
- result_lo, result_hi  output  WIDTH  product words.

## Operation
- States:
  - IDLE -> ITER on start & !flush, with operands latched.
  - ITER -> FIX after the last iteration.
  - FIX -> DONE.
  - DONE -> IDLE.
  - flush in any state -> IDLE, with no write.
- Latch step:
  - Signed (SMULL): magnitudes |a| and |b| are latched.
  - Sign flag = a[WIDTH-1] ^ b[WIDTH-1].
  - Unsigned and MUL use the raw operand values.
- ITER: each cycle, if the multiplier LSB is 1, add the multiplicand into the 2*WIDTH accumulator; then shift the multiplicand left and the multiplier right. Iteration count is exactly WIDTH.
- FIX: if the sign flag is set, the accumulator becomes its two's complement over 2*WIDTH bits.
- DONE: done=1.
  - MUL: we=01, wa3=wa_lo, result_lo = product[WIDTH-1:0].
  - UMULL/SMULL: we=11, wa3=wa_lo, wa3_2=wa_hi.
  - Long op with wa_lo==wa_hi: we=10, so only the high word is written.
- stall = (state==IDLE & start & !flush) | state==ITER | state==FIX. It is deasserted in DONE, so the pipeline advances in the same cycle the write-back occurs.
- start while not in IDLE is ignored; the requester holds start under stall.
- Reset values: state IDLE; stall, done and we 0; wa3, wa3_2, result_lo, result_hi 0.
- Reset mid-operation: immediate return to IDLE with all outputs cleared; no partial write.

## Timing
- start is sampled high at edge k.
- ITER occupies cycles k+1..k+WIDTH.
- FIX occupies cycle k+WIDTH+1.
- done is high for cycle k+WIDTH+2 only. Latency is 34 cycles for WIDTH=32.
- done, we, wa3, wa3_2, result_lo and result_hi are registered outputs.
- stall is combinational from start and registered state.
- flush sampled at an edge takes effect at that edge.
- flush and start high together in IDLE: flush wins.
- flush in DONE: done, which was already asserted for that cycle, remains valid; the next state is IDLE.

## Configuration
- MUL_EARLY_TERM_EN
  - Defined: ITER exits to FIX once the remaining shifted multiplier is zero, after at least one iteration. Iterations = max(1, index of the highest set bit of the latched multiplier + 1).
  - Undefined: always exactly WIDTH iterations. Results are identical either way; only latency differs.

## Test plan
- MUL, src_a=7, src_b=6, wa_lo=2:
  - done exactly 34 cycles after start.
  - we=01, wa3=2, result_lo=42.
  - stall high for cycles 0..33.
- UMULL, src_a=src_b=0xFFFFFFFF, wa_lo=1, wa_hi=3 -> result_hi=0xFFFFFFFE, result_lo=0x00000001, we=11, wa3=1, wa3_2=3.
- SMULL, src_a=-3, src_b=5 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFF1, we=11.
- Flush:
  - Flush at iteration 10 -> no done pulse, stall low the next cycle.
  - A new start (MUL 2*2) is then accepted and yields 4.
- Reset:
  - reset driven to 0 at iteration 20 -> stall, done and we are 0 immediately.
  - After release, MUL 9*9 yields 81.
- MUL_EARLY_TERM_EN defined, MUL 3*5 -> 3 iterations, done 5 cycles after start, result_lo=15; the same test with the macro undefined gives 34 cycles.
